// File: rtl/calculadora_uc.sv
`default_nettype none
// ============================================================================
//  Module      : calculadora_uc
//  Description : Multicycle control unit for the calculator datapath. Fetches
//                one RV32I-subset instruction at a time from a synchronous
//                ROM, decodes it into register-file / ALU control fields,
//                pulses the register-file write and advances the PC. Supports
//                single-step (opera) and free-run (run) operation and halts
//                on an all-zero word or on an unsupported encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
module calculadora_uc #(
    parameter int PC_W = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            opera,
    input  logic            run,
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [11:0]     imm,
    output logic            alu_src,
    output logic [2:0]      alu_op,
    output logic            rf_we,
    output logic            busy,
    output logic            done,
    output logic            halted,
    output logic            illegal
);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_FETCH  = 3'd1;
    localparam logic [2:0] C_DECODE = 3'd2;
    localparam logic [2:0] C_EXEC   = 3'd3;
    localparam logic [2:0] C_WB     = 3'd4;
    localparam logic [2:0] C_HALT   = 3'd5;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_SLL = 3'b010;
    localparam logic [2:0] C_ALU_SRL = 3'b011;
    localparam logic [2:0] C_ALU_XOR = 3'b100;
    localparam logic [2:0] C_ALU_OR  = 3'b110;
    localparam logic [2:0] C_ALU_AND = 3'b111;

    localparam logic [6:0] C_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] C_OPC_OP    = 7'b0110011;
    localparam logic [6:0] C_F7_ZERO   = 7'b0000000;
    localparam logic [6:0] C_F7_SUB    = 7'b0100000;

    localparam logic [PC_W-1:0] C_PC_STEP = PC_W'(4);

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    // Only the operand fields of the instruction are kept; opcode and funct3
    // are consumed during DECODE and never needed afterwards.
    logic [21:0]     r_ir;
    logic            r_alu_src;
    logic [2:0]      r_alu_op;
    logic            r_done;
    logic            r_illegal;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_legal;
    logic            w_src;
    logic [2:0]      w_op;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    // Decode the ROM word: legality, operand source and ALU operation.
    always_comb begin
        w_legal = 1'b0;
        w_src   = 1'b0;
        w_op    = C_ALU_ADD;
        case (w_opcode)
            C_OPC_OPIMM: begin
                w_src = 1'b1;
                case (w_funct3)
                    3'b000: begin w_legal = 1'b1;                   w_op = C_ALU_ADD; end
                    3'b001: begin w_legal = (w_funct7 == C_F7_ZERO); w_op = C_ALU_SLL; end
                    3'b100: begin w_legal = 1'b1;                   w_op = C_ALU_XOR; end
                    3'b101: begin w_legal = (w_funct7 == C_F7_ZERO); w_op = C_ALU_SRL; end
                    3'b110: begin w_legal = 1'b1;                   w_op = C_ALU_OR;  end
                    3'b111: begin w_legal = 1'b1;                   w_op = C_ALU_AND; end
                    default: w_legal = 1'b0;
                endcase
            end
            C_OPC_OP: begin
                w_src = 1'b0;
                case (w_funct3)
                    3'b000: begin
                        if (w_funct7 == C_F7_ZERO) begin
                            w_legal = 1'b1;
                            w_op    = C_ALU_ADD;
                        end else if (w_funct7 == C_F7_SUB) begin
                            w_legal = 1'b1;
                            w_op    = C_ALU_SUB;
                        end
                    end
                    3'b001: begin w_legal = (w_funct7 == C_F7_ZERO); w_op = C_ALU_SLL; end
                    3'b100: begin w_legal = (w_funct7 == C_F7_ZERO); w_op = C_ALU_XOR; end
                    3'b101: begin w_legal = (w_funct7 == C_F7_ZERO); w_op = C_ALU_SRL; end
                    3'b110: begin w_legal = (w_funct7 == C_F7_ZERO); w_op = C_ALU_OR;  end
                    3'b111: begin w_legal = (w_funct7 == C_F7_ZERO); w_op = C_ALU_AND; end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Sequencer: state, PC, instruction register and registered decode fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= C_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_alu_src <= 1'b0;
            r_alu_op  <= C_ALU_ADD;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done <= (r_state == C_WB);
            case (r_state)
                C_IDLE: begin
                    if (opera || run) begin
                        r_state <= C_FETCH;
                    end
                end
                C_FETCH: begin
                    r_state <= C_DECODE;
                end
                C_DECODE: begin
                    r_ir <= {instr[31:15], instr[11:7]};
                    if (instr == 32'h0000_0000) begin
                        r_state <= C_HALT;
                    end else if (!w_legal) begin
                        r_state   <= C_HALT;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state   <= C_EXEC;
                        r_alu_src <= w_src;
                        r_alu_op  <= w_op;
                    end
                end
                C_EXEC: begin
                    r_state <= C_WB;
                end
                C_WB: begin
                    r_pc    <= r_pc + C_PC_STEP;
                    r_state <= C_IDLE;
                end
                C_HALT: begin
                    r_state <= C_HALT;
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign pc      = r_pc;
    assign ir_load = (r_state == C_DECODE);
    assign imm     = r_ir[21:10];
    assign rs2     = r_ir[14:10];
    assign rs1     = r_ir[9:5];
    assign rd      = r_ir[4:0];
    assign alu_src = r_alu_src;
    assign alu_op  = r_alu_op;
    // A reset arriving during WB cancels the write in that same cycle.
    assign rf_we   = (r_state == C_WB) && !reset;
    assign busy    = (r_state == C_FETCH) || (r_state == C_DECODE) ||
                     (r_state == C_EXEC)  || (r_state == C_WB);
    assign done    = r_done;
    assign halted  = (r_state == C_HALT);
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_calculadora_uc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calculadora_uc
//  Description : Self-checking bench for calculadora_uc. Stimulus pushes the
//                expected writeback of each instruction into a queue; a
//                monitor pops and compares on every rf_we pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calculadora_uc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        opera = 1'b0;
    logic        run   = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [9:0]  pc;
    logic        ir_load, alu_src, rf_we, busy, done, halted, illegal;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic [2:0]  alu_op;

    logic        run4   = 1'b0;
    logic [31:0] instr4 = 32'h0;
    logic [3:0]  pc4;
    logic        ir_load4, alu_src4, rf_we4, busy4, done4, halted4, illegal4;
    logic [4:0]  rs1_4, rs2_4, rd_4;
    logic [11:0] imm4;
    logic [2:0]  alu_op4;

    calculadora_uc #(.PC_W(10)) dut (
        .clock(clock), .reset(reset), .opera(opera), .run(run), .instr(instr),
        .pc(pc), .ir_load(ir_load), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .alu_src(alu_src), .alu_op(alu_op), .rf_we(rf_we), .busy(busy),
        .done(done), .halted(halted), .illegal(illegal)
    );

    calculadora_uc #(.PC_W(4)) dut4 (
        .clock(clock), .reset(reset), .opera(1'b0), .run(run4), .instr(instr4),
        .pc(pc4), .ir_load(ir_load4), .rs1(rs1_4), .rs2(rs2_4), .rd(rd_4), .imm(imm4),
        .alu_src(alu_src4), .alu_op(alu_op4), .rf_we(rf_we4), .busy(busy4),
        .done(done4), .halted(halted4), .illegal(illegal4)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] rom  [256];
    logic [31:0] rom4 [4];

    // Legal-instruction table: bits under mask must equal match.
    logic [31:0] t_mask [13] = '{32'h0000707F, 32'hFE00707F, 32'h0000707F, 32'hFE00707F,
                                 32'h0000707F, 32'h0000707F, 32'hFE00707F, 32'hFE00707F,
                                 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                                 32'hFE00707F};
    logic [31:0] t_match [13] = '{32'h00000013, 32'h00001013, 32'h00004013, 32'h00005013,
                                  32'h00006013, 32'h00007013, 32'h00000033, 32'h40000033,
                                  32'h00001033, 32'h00005033, 32'h00004033, 32'h00006033,
                                  32'h00007033};
    logic [2:0]  t_op  [13] = '{3'b000, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111,
                                3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
    logic        t_src [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [9:0]  pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        src;
        logic [2:0]  op;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [9:0] mpc = '0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        instr  <= rom[pc[9:2]];
        instr4 <= rom4[pc4[3:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic bit lookup(input logic [31:0] w, output logic [2:0] op, output logic src);
        lookup = 1'b0;
        op     = 3'b000;
        src    = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if ((w & t_mask[i]) == t_match[i]) begin
                lookup = 1'b1;
                op     = t_op[i];
                src    = t_src[i];
            end
        end
    endfunction

    function automatic logic [31:0] rnd_legal();
        int i;
        i = $urandom_range(0, 12);
        return ($urandom & ~t_mask[i]) | t_match[i];
    endfunction

    function automatic logic [31:0] rnd_illegal();
        logic [31:0] w;
        logic [2:0]  o;
        logic        s;
        do w = $urandom; while (w == 32'h0 || lookup(w, o, s));
        return w;
    endfunction

    // Scoreboard monitor: every writeback must match the oldest expectation.
    always @(negedge clock) begin
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected rf_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb pc",      {22'h0, pc},      {22'h0, mon_e.pc});
                chk("wb rd",      {27'h0, rd},      {27'h0, mon_e.rd});
                chk("wb rs1",     {27'h0, rs1},     {27'h0, mon_e.rs1});
                chk("wb rs2",     {27'h0, rs2},     {27'h0, mon_e.rs2});
                chk("wb imm",     {20'h0, imm},     {20'h0, mon_e.imm});
                chk("wb alu_src", {31'h0, alu_src}, {31'h0, mon_e.src});
                chk("wb alu_op",  {29'h0, alu_op},  {29'h0, mon_e.op});
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        opera = 1'b0;
        run   = 1'b0;
        run4  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mpc   = '0;
    endtask

    // One instruction from IDLE, checking cycle-by-cycle timing against the model.
    task automatic step(input bit use_op, input bit use_run, input bit noise);
        logic [31:0] w;
        bit          ok, zero;
        logic [2:0]  op;
        logic        src;
        exp_t        e;
        w    = rom[mpc[9:2]];
        zero = (w == 32'h0);
        ok   = lookup(w, op, src);
        if (ok) begin
            e.pc = mpc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.imm = w[31:20]; e.src = src; e.op = op;
            exp_q.push_back(e);
        end
        @(negedge clock);
        opera = use_op;
        run   = use_run;
        @(negedge clock);
        opera = noise;
        run   = 1'b0;
        chk("busy in fetch", {31'h0, busy}, 32'd1);
        @(negedge clock);
        chk("ir_load in decode", {31'h0, ir_load}, 32'd1);
        opera = noise;
        @(negedge clock);
        opera = 1'b0;
        @(negedge clock);
        chk("rf_we at start+4", {31'h0, rf_we}, {31'h0, ok});
        @(negedge clock);
        if (ok) mpc = mpc + 10'd4;
        chk("done at start+5", {31'h0, done}, {31'h0, ok});
        chk("halted", {31'h0, halted}, {31'h0, !ok});
        chk("illegal", {31'h0, illegal}, {31'h0, (!ok && !zero)});
        chk("pc after instr", {22'h0, pc}, {22'h0, mpc});
        chk("idle after instr", {31'h0, busy}, 32'd0);
    endtask

    task automatic poke_halted(input bit exp_illegal);
        @(negedge clock);
        opera = 1'b1;
        run   = 1'b1;
        @(negedge clock);
        opera = 1'b0;
        run   = 1'b0;
        repeat (5) @(negedge clock);
        chk("halt absorbing", {31'h0, halted}, 32'd1);
        chk("halt busy", {31'h0, busy}, 32'd0);
        chk("halt pc frozen", {22'h0, pc}, {22'h0, mpc});
        chk("halt illegal sticky", {31'h0, illegal}, {31'h0, exp_illegal});
    endtask

    task automatic abort_at(input bit in_wb);
        @(negedge clock);
        opera = 1'b1;
        @(negedge clock);
        opera = 1'b0;
        @(negedge clock);
        @(negedge clock);
        if (!in_wb) begin
            reset = 1'b1;
        end else begin
            @(posedge clock);
            #2 reset = 1'b1;
            #1 chk("rf_we killed by reset in wb", {31'h0, rf_we}, 32'd0);
        end
        @(posedge clock);
        @(negedge clock);
        chk("abort busy", {31'h0, busy}, 32'd0);
        chk("abort pc", {22'h0, pc}, 32'd0);
        chk("abort done", {31'h0, done}, 32'd0);
        chk("abort rf_we", {31'h0, rf_we}, 32'd0);
        reset = 1'b0;
        mpc   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n, cnt;
        int          wc [$];
        logic [9:0]  q4 [$];
        logic [31:0] term;
        bit          mode_op, mode_run;

        for (int i = 0; i < 256; i++) rom[i] = 32'h0;

        // Reset state.
        do_reset();
        chk("reset pc", {22'h0, pc}, 32'd0);
        chk("reset busy", {31'h0, busy}, 32'd0);
        chk("reset done", {31'h0, done}, 32'd0);
        chk("reset halted", {31'h0, halted}, 32'd0);
        chk("reset illegal", {31'h0, illegal}, 32'd0);
        chk("reset rf_we", {31'h0, rf_we}, 32'd0);
        chk("reset ir_load", {31'h0, ir_load}, 32'd0);
        chk("reset alu", {28'h0, alu_src, alu_op}, 32'd0);
        chk("reset fields", {5'h0, rs1, rs2, rd, imm}, 32'd0);

        // Single step: addi x1,x0,5.
        rom[0] = {12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011};
        step(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("done single pulse", {31'h0, done}, 32'd0);

        // Free-run program, run dropped at the 4th writeback.
        do_reset();
        rom[0] = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        rom[1] = {7'b0100000, 5'd1, 5'd3, 3'b000, 5'd4, 7'b0110011};
        rom[2] = {12'hFFF,    5'd4, 3'b100, 5'd5, 7'b0010011};
        rom[3] = {7'b0000000, 5'd2, 5'd5, 3'b101, 5'd6, 7'b0010011};
        rom[4] = rnd_legal();
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            logic [2:0] op;
            logic       src;
            void'(lookup(rom[i], op, src));
            e.pc = 10'(4 * i); e.rd = rom[i][11:7]; e.rs1 = rom[i][19:15];
            e.rs2 = rom[i][24:20]; e.imm = rom[i][31:20]; e.src = src; e.op = op;
            exp_q.push_back(e);
        end
        @(negedge clock);
        run = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 4; k++) begin
            @(negedge clock);
            if (rf_we) begin
                cnt++;
                wc.push_back(cyc);
            end
        end
        run = 1'b0;
        chk("run instr count", cnt, 4);
        for (int i = 1; i < wc.size(); i++) chk("run rf_we spacing", wc[i] - wc[i-1], 5);
        @(negedge clock);
        @(negedge clock);
        chk("run stops in idle", {30'h0, busy, halted}, 32'd0);
        chk("run final pc", {22'h0, pc}, 32'd16);

        // Randomized programs, each ending in a halting word.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            n = (r == 0) ? 2 : int'($urandom_range(5, 15));
            for (int i = 0; i < n; i++) rom[i] = rnd_legal();
            case (r)
                0:       term = 32'h0000_0000;
                1:       term = 32'h0000_0073;
                2:       term = {7'b0100001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
                default: term = rnd_illegal();
            endcase
            rom[n] = term;
            for (int i = 0; i <= n; i++) begin
                case ($urandom_range(0, 2))
                    0:       begin mode_op = 1'b1; mode_run = 1'b0; end
                    1:       begin mode_op = 1'b0; mode_run = 1'b1; end
                    default: begin mode_op = 1'b1; mode_run = 1'b1; end
                endcase
                step(mode_op, mode_run, 1'($urandom_range(0, 1)));
            end
            poke_halted(r != 0);
        end

        // Reset aborting an instruction in EXEC and in WB.
        do_reset();
        chk("reset leaves halt", {31'h0, halted}, 32'd0);
        for (int i = 0; i < 3; i++) rom[i] = rnd_legal();
        step(1'b1, 1'b0, 1'b0);
        abort_at(1'b0);
        step(1'b1, 1'b0, 1'b1);
        abort_at(1'b1);
        step(1'b0, 1'b1, 1'b0);

        // 4-bit PC wraps 12 -> 0 in free-run mode.
        do_reset();
        for (int i = 0; i < 4; i++) rom4[i] = rnd_legal();
        @(negedge clock);
        run4 = 1'b1;
        for (int k = 0; k < 80 && q4.size() < 6; k++) begin
            @(negedge clock);
            if (rf_we4) q4.push_back({6'h0, pc4});
        end
        run4 = 1'b0;
        chk("wrap instr count", q4.size(), 6);
        for (int i = 0; i < q4.size(); i++) chk("wrap pc sequence", {22'h0, q4[i]}, 32'((i % 4) * 4));

        repeat (3) @(negedge clock);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calculadora_uc.md
# calculadora_uc

Multicycle control unit that sequences the calculator datapath (instruction ROM, register file, ALU) one instruction at a time. It fetches a 32-bit RV32I-subset instruction, decodes it into register-file/ALU control fields, and pulses the writeback. It then advances the program counter. It supports single-step (`opera` pulse) and free-run modes, and it halts on an end-of-program marker or an illegal encoding.

## Interface
Parameters:
- `PC_W`, default 10: program-counter width (byte address). The ROM spans 2^PC_W bytes.

Ports:
- `clock`: in, 1, single clock; all state updates on rising edge.
- `reset`: in, 1, synchronous, active-high.
- `opera`: in, 1, execute one instruction; sampled only in IDLE.
- `run`: in, 1, level; when high, the next instruction auto-starts from IDLE.
- `instr`: in, 32, ROM read data; valid one cycle after `pc` is presented (synchronous ROM).
- `pc`: out, PC_W, current instruction byte address.
- `ir_load`: out, 1, loads the instruction register (asserted in DECODE).
- `rs1`, `rs2`, `rd`: out, 5 each, register fields from the latched instruction.
- `imm`: out, 12, raw I-type immediate (instr[31:20]); the datapath sign-extends it.
- `alu_src`: out, 1, 0 = rs2 operand, 1 = immediate.
- `alu_op`: out, 3, 000 add, 001 sub, 010 sll, 011 srl, 100 xor, 110 or, 111 and.
- `rf_we`: out, 1, register-file write enable, one-cycle pulse in WB.
- `busy`: out, 1, high in FETCH/DECODE/EXEC/WB.
- `done`: out, 1, one-cycle pulse in the cycle after WB.
- `halted`: out, 1, sticky; high in HALT.
- `illegal`: out, 1, sticky; set together with `halted` on an unsupported encoding.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE:
  - `opera`=1 or `run`=1 → FETCH.
  - Otherwise stay in IDLE.
- FETCH: `pc` is held stable and the ROM access is in progress → DECODE.
- DECODE: `ir_load`=1 and IR ← `instr`.
  - Decode is evaluated on `instr` → EXEC.
  - Exception: if `instr`==32'h0000_0000 → HALT with `illegal`=0 (end of program).
- Supported encodings:
  - OP-IMM (opcode 0010011): funct3 000 addi, 001 slli (funct7 must be 0), 100 xori, 101 srli (funct7 must be 0), 110 ori, 111 andi. `alu_src`=1.
  - OP (opcode 0110011): funct3 000 with funct7 0000000 add / 0100000 sub, 001 sll, 101 srl, 100 xor, 110 or, 111 and. All other funct7 values are illegal. `alu_src`=0.
  - Anything else is illegal → HALT with `illegal`=1. The IR still loads; `rf_we` is never asserted.
- EXEC: `rs1`, `rs2`, `rd`, `imm`, `alu_src` and `alu_op` are stable from IR; the ALU settles → WB.
- WB: `rf_we`=1 for exactly one cycle. `pc` ← `pc`+4 at the end of WB, modulo 2^PC_W (wraps to 0) → IDLE.
- `rf_we` fires for every rd, including rd=0. x0 policy belongs to the register file.
- `done` is registered: it is high in the first IDLE cycle after WB.
- HALT: absorbing. `opera` and `run` are ignored; `pc` is frozen at the halting instruction's address. Only `reset` exits.
- `opera` is ignored while `busy`=1; there is no queueing.
- Decode fields stay stable from EXEC until the next DECODE.

## Timing
- Reset (synchronous, priority over everything):
  - State → IDLE.
  - `pc`, IR, and all outputs → 0.
  - `alu_op` → 000.
- Reset asserted mid-instruction (any of FETCH..WB) aborts the instruction: no `rf_we` and no `pc` increment in that cycle.
- Latency: `opera` sampled high at edge N gives FETCH in cycle N+1, DECODE N+2, EXEC N+3, WB N+4, and `done` in cycle N+5.
- Throughput:
  - Step mode: one instruction per 5 cycles minimum (a new `opera` is accepted in the `done` cycle).
  - Run mode: back-to-back with a 5-cycle period (IDLE lasts exactly 1 cycle).
- Simultaneous `opera`=1 and `run`=1 in IDLE: one start, identical to either alone.
- `run` dropped mid-instruction: the current instruction completes; the controller then waits in IDLE.

## Test plan
- Reset, then ROM[0]=addi x1,x0,5 with one `opera` pulse → exactly one `rf_we` pulse 4 cycles later; at WB `rd`=1, `rs1`=0, `imm`=5, `alu_src`=1, `alu_op`=000; `pc` goes 0→4 and `done` pulses once.
- Program add x3,x1,x2 / sub x4,x3,x1 / xori x5,x4,-1 / srli x6,x5,2 in run mode → expect `alu_op` 000/001/100/011, `imm` 0xFFF for xori, `pc` ending at 16, and 5-cycle spacing between `rf_we` pulses.
- Instruction word 0 at pc=8 → `halted`=1, `illegal`=0, `pc` stays 8, no `rf_we`; further `opera` pulses have no effect.
- Illegal encoding 0x0000_0073 (ecall), and add with funct7 0100001 → `halted`=1, `illegal`=1, no `rf_we`.
- `opera` pulsed during DECODE and EXEC → ignored; exactly one instruction executes. `reset` asserted in EXEC → no `rf_we`, `pc`=0, state IDLE on the next cycle.
- PC_W=4 with 4 valid instructions in run mode → `pc` wraps 12→0 and execution restarts at instruction 0.
